// File: rtl/metro_mpi_pkg.sv
// Shared types and constants for the MPI sender/receiver pair.
package metro_mpi_pkg;

  // Receive FIFO depth; must cover the sender's initial credit count of 7.
  localparam int RX_DEPTH = 8;

  // Width of credit / occupancy counters, wide enough to hold RX_DEPTH itself.
  localparam int CREDIT_WIDTH = $clog2(RX_DEPTH) + 1;

  // First word of the incrementing test pattern; the sender resets to the same value.
  localparam logic [63:0] PATTERN_SEED = 64'hcafe_cafe_cafe_cafe;

  typedef logic [63:0] flit_t;

endpackage

// File: rtl/metro_mpi_fifo.sv
// Synchronous first-word-fall-through FIFO. Head entry is visible on head_o
// whenever the FIFO is non-empty; head_o reads as zero when empty.
module metro_mpi_fifo
  import metro_mpi_pkg::*;
#(
  parameter int DEPTH  = RX_DEPTH,
  parameter int DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic              do_push;
  logic              do_pop;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Storage write; contents need no reset because pointers define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

  // Pointer update; reset discards everything buffered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

endmodule

// File: rtl/receiver_mpi.sv
// Credit-based receive stage: buffers flits from the MPI sender, returns one
// yummy per flit drained, checks the incrementing pattern and counts flits.
module receiver_mpi
  import metro_mpi_pkg::*;
#(
  parameter int DEPTH  = RX_DEPTH,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       rank_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              yummy_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ready_i,
  output logic [CNT_W-1:0]  rx_count_o,
  output logic              seq_err_o,
  output logic              overflow_o
);

  logic              active;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              drop;
  logic              yummy_q;
  logic [CNT_W-1:0]  rx_count_q;
  logic              seq_err_q;
  logic              overflow_q;
  logic [DATA_W-1:0] expected_q;

  // Rank 0 is the sender itself, so the receiver stays idle there.
  assign active  = (rank_i != 32'd0);
  assign valid_o = active & ~fifo_empty;
  assign pop     = valid_o & ready_i;
  assign push    = valid_i & active & (~fifo_full | pop);
  assign drop    = valid_i & active & fifo_full & ~pop;

  metro_mpi_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (data_i),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (data_o)
  );

  // Credit return: one registered pulse for each flit leaving the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      yummy_q <= 1'b0;
    end else begin
      yummy_q <= pop;
    end
  end

  // Pattern checker, flit counter and sticky overflow flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      expected_q <= DATA_W'(PATTERN_SEED);
      seq_err_q  <= 1'b0;
      rx_count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        if (data_i != expected_q) seq_err_q <= 1'b1;
        // Resync to whatever arrived so a single glitch is not reported forever.
        expected_q <= data_i + DATA_W'(1);
        rx_count_q <= rx_count_q + CNT_W'(1);
      end
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign yummy_o    = yummy_q;
  assign rx_count_o = rx_count_q;
  assign seq_err_o  = seq_err_q;
  assign overflow_o = overflow_q;

endmodule
